// File: rtl/spike_select_network_if.sv
// Output handshake bundle of the spike-selection network.
// Master drives {data, id} words; slave returns ready.
interface spike_select_network_if #(
   parameter int TEN_DATA_WIDTH  = 2,
   parameter int NEURON_ID_WIDTH = 7
);
   logic                                      out_valid;
   logic                                      out_ready;
   logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out;

   modport master (
      output out_valid,
      output spike_out,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  spike_out,
      output out_ready
   );
endinterface

// File: rtl/spike_select_network.sv
// Spike-selection network: snapshots spikes, then streams {data, id}
// words with ids from a masked LFSR or a sequential sweep.
module spike_select_network #(
   parameter int                         TEN_DATA_WIDTH  = 2,
   parameter int                         NUM_NEURON      = 128,
   parameter int                         NEURON_ID_WIDTH = 7,
   parameter logic [NEURON_ID_WIDTH-1:0] LFSR_TAPS       = 7'b110_0000,
   parameter logic [NEURON_ID_WIDTH-1:0] LFSR_SEED       = 7'b100_1011
) (
   input  logic                               clk,
   input  logic                               reset_l,
   input  logic                               top_en_network,
   input  logic                               en_network,
   input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0] spike_in,
   input  logic [3:0]                         bits_in_active_neuron,
   input  logic                               mode,
   input  logic [NEURON_ID_WIDTH:0]           num_picks,
   spike_select_network_if.master             out_if,
   output logic                               busy,
   output logic                               networkDone
);
   localparam int W   = NEURON_ID_WIDTH;
   localparam int DW  = TEN_DATA_WIDTH;
   localparam int SW  = DW * NUM_NEURON;
   localparam int SIW = (SW > 1) ? $clog2(SW) : 1;
   localparam logic [W-1:0] SEED = (LFSR_SEED == '0) ? W'(1) : LFSR_SEED;
   localparam logic [3:0]   MAXB = 4'(W);
   localparam logic [W:0]   ONE  = (W+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

   state_t            r_state;
   logic [W-1:0]      r_lfsr;
   logic [W-1:0]      r_seq;
   logic [SW-1:0]     r_snap;
   logic              r_mode;
   logic [3:0]        r_bits;
   logic [W:0]        r_cnt;
   logic              r_valid;
   logic [DW+W-1:0]   r_word;
   logic              r_busy;
   logic              r_done;

   logic              w_idle;
   logic [3:0]        w_bits_clamp;
   logic [3:0]        w_bits;
   logic              w_mode;
   logic [W-1:0]      w_mask;
   logic [W-1:0]      w_lfsr_nx;
   logic [W-1:0]      w_seq_nx;
   logic [W-1:0]      w_id;
   logic [SW-1:0]     w_src;
   logic [SIW-1:0]    w_base;
   logic [DW-1:0]     w_data;
   logic              w_accept;

   always_comb begin
      w_bits_clamp = bits_in_active_neuron;
      if (bits_in_active_neuron == 4'd0)
         w_bits_clamp = 4'd1;
      else if (bits_in_active_neuron > MAXB)
         w_bits_clamp = MAXB;
   end

   // At the start edge the id is built from the live inputs being latched
   assign w_idle    = (r_state == S_IDLE);
   assign w_bits    = w_idle ? w_bits_clamp : r_bits;
   assign w_mode    = w_idle ? mode : r_mode;
   assign w_mask    = W'((32'd1 << w_bits) - 32'd1);
   assign w_lfsr_nx = {r_lfsr[W-2:0], ^(r_lfsr & LFSR_TAPS)};
   assign w_seq_nx  = w_idle ? '0 : ((r_seq + 1'b1) & w_mask);
   assign w_id      = w_mode ? w_seq_nx : (w_lfsr_nx & w_mask);
   assign w_src     = w_idle ? spike_in : r_snap;
   assign w_base    = SIW'(32'(w_id) * DW);
   assign w_data    = (32'(w_id) < NUM_NEURON) ? w_src[w_base +: DW] : '0;
   assign w_accept  = r_valid & out_if.out_ready;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_state <= S_IDLE;
         r_lfsr  <= SEED;
         r_seq   <= '0;
         r_snap  <= '0;
         r_mode  <= 1'b0;
         r_bits  <= 4'd1;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_word  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (top_en_network) begin
         unique case (r_state)
            S_IDLE: begin
               if (en_network) begin
                  r_snap <= spike_in;
                  r_mode <= mode;
                  r_bits <= w_bits_clamp;
                  r_cnt  <= num_picks;
                  r_busy <= 1'b1;
                  if (num_picks == '0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_EMIT;
                     r_valid <= 1'b1;
                     r_word  <= {w_data, w_id};
                     r_seq   <= w_seq_nx;
                     if (!mode) r_lfsr <= w_lfsr_nx;
                  end
               end
            end
            S_EMIT: begin
               if (w_accept) begin
                  if (r_cnt == ONE) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt  <= r_cnt - 1'b1;
                     r_word <= {w_data, w_id};
                     r_seq  <= w_seq_nx;
                     if (!r_mode) r_lfsr <= w_lfsr_nx;
                  end
               end
            end
            S_DONE: begin
               // An empty pass enters here without the pulse, so raise it first
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_if.out_valid = r_valid;
   assign out_if.spike_out = r_word;
   assign busy             = r_busy;
   assign networkDone      = r_done;
endmodule

// File: tb/tb_spike_select_network.sv
// Directed bench for spike_select_network with a scoreboard queue
// of expected {data, id} words filled at each start request.
module tb_spike_select_network;
   localparam int DW = 2;
   localparam int NN = 128;
   localparam int W  = 7;
   localparam int SW = DW * NN;
   localparam logic [W-1:0] TAPS = 7'b110_0000;
   localparam logic [W-1:0] SEED = 7'b100_1011;

   logic          clk = 1'b0;
   logic          reset_l = 1'b0;
   logic          top_en = 1'b1;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [SW-1:0] spike = '0;
   logic [3:0]    bits = 4'd7;
   logic [W:0]    npk = '0;
   logic          busy;
   logic          done;

   int passes = 0;
   int total  = 0;
   logic [DW+W-1:0] q[$];
   logic [W-1:0]    m_lfsr = SEED;

   spike_select_network_if #(.TEN_DATA_WIDTH(DW), .NEURON_ID_WIDTH(W)) bus ();

   spike_select_network dut (
      .clk                   (clk),
      .reset_l               (reset_l),
      .top_en_network        (top_en),
      .en_network            (en),
      .spike_in              (spike),
      .bits_in_active_neuron (bits),
      .mode                  (mode),
      .num_picks             (npk),
      .out_if                (bus),
      .busy                  (busy),
      .networkDone           (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) passes++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] step(input logic [W-1:0] x);
      return {x[W-2:0], ^(x & TAPS)};
   endfunction

   task automatic do_reset();
      reset_l = 1'b0;
      en = 1'b0;
      top_en = 1'b1;
      bus.out_ready = 1'b1;
      q.delete();
      m_lfsr = SEED;
      repeat (2) @(posedge clk);
      #1 reset_l = 1'b1;
   endtask

   task automatic randomize_spikes();
      for (int i = 0; i < SW / 32; i++)
         spike[i*32 +: 32] = $urandom;
   endtask

   // Queue the expected words, then issue the start and corrupt spike_in
   task automatic start(input logic md, input logic [3:0] b,
                        input logic [W:0] n);
      int bb;
      logic [W-1:0] mask;
      logic [W-1:0] id;
      logic [DW-1:0] d;
      bb = (b == 4'd0) ? 1 : ((int'(b) > W) ? W : int'(b));
      mask = W'((1 << bb) - 1);
      id = '0;
      for (int i = 0; i < int'(n); i++) begin
         if (!md) begin
            m_lfsr = step(m_lfsr);
            id = m_lfsr & mask;
         end else begin
            id = (i == 0) ? '0 : W'((id + 1'b1) & mask);
         end
         d = (int'(id) < NN) ? spike[int'(id)*DW +: DW] : '0;
         q.push_back({d, id});
      end
      mode = md;
      bits = b;
      npk = n;
      en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      spike = ~spike;
   endtask

   task automatic drain(input int first_id, input int nwords,
                        input int stall_at, input int stall_len,
                        input int gate_at, input int gate_len);
      int acc = 0;
      int stall = 0;
      int gate = 0;
      int cyc = 0;
      logic [DW+W-1:0] held = '0;
      logic [DW+W-1:0] exp;
      while (q.size() > 0 && cyc < 200) begin
         bus.out_ready = !(acc == stall_at && stall < stall_len);
         top_en = !(acc == gate_at && gate < gate_len);
         @(negedge clk);
         if (cyc == 0) begin
            chk("start_busy", busy, 1);
            if (first_id >= 0)
               chk("first_id", bus.spike_out[W-1:0], first_id);
         end
         chk("valid_held", bus.out_valid, 1);
         chk("no_early_done", done, 0);
         if (!bus.out_ready) begin
            stall++;
            if (stall == 1) held = bus.spike_out;
            else chk("stall_stable", bus.spike_out, held);
         end
         if (!top_en) gate++;
         if (bus.out_ready && top_en) begin
            exp = q.pop_front();
            chk("word", bus.spike_out, exp);
            acc++;
         end
         @(posedge clk);
         #1 cyc++;
      end
      bus.out_ready = 1'b1;
      top_en = 1'b1;
      chk("drained", q.size(), 0);
      chk("pass_cycles", cyc, nwords + stall_len + gate_len);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("valid_drop", bus.out_valid, 0);
      chk("busy_in_done", busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_fall", busy, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW+W-1:0] exp;
      bus.out_ready = 1'b1;
      randomize_spikes();
      do_reset();
      @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_word", bus.spike_out, 0);
      @(posedge clk);
      #1;

      // Random B=7: ids 23, 46, 93
      start(1'b0, 4'd7, 8'd3);
      drain(23, 3, -1, 0, -1, 0);

      // Random B=4 from seed: ids 7, 14, 13
      do_reset();
      randomize_spikes();
      start(1'b0, 4'd4, 8'd3);
      drain(7, 3, -1, 0, -1, 0);

      // Sequential B=2: 0, 1, 2, 3, 0
      randomize_spikes();
      start(1'b1, 4'd2, 8'd5);
      drain(0, 5, -1, 0, -1, 0);

      // Clamp B=0 to one bit: 0, 1, 0
      start(1'b1, 4'd0, 8'd3);
      drain(0, 3, -1, 0, -1, 0);

      // Backpressure on word 2 in random mode
      randomize_spikes();
      start(1'b0, 4'd7, 8'd4);
      drain(-1, 4, 1, 3, -1, 0);

      // Empty pass
      start(1'b0, 4'd7, 8'd0);
      @(negedge clk);
      chk("zero_valid", bus.out_valid, 0);
      chk("zero_done_k", done, 0);
      chk("zero_busy", busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("zero_done_k1", done, 1);
      chk("zero_valid2", bus.out_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("zero_done_clr", done, 0);
      chk("zero_busy_fall", busy, 0);
      @(posedge clk);
      #1;

      // Global enable low for two cycles mid-pass
      start(1'b1, 4'd7, 8'd4);
      drain(0, 4, 2, 0, 2, 2);

      // Reset during word 2, then a fresh pass restarts at 23
      do_reset();
      start(1'b0, 4'd7, 8'd3);
      @(negedge clk);
      exp = q.pop_front();
      chk("pre_rst_word", bus.spike_out, exp);
      @(posedge clk);
      #3 reset_l = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_word", bus.spike_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      q.delete();
      m_lfsr = SEED;
      @(posedge clk);
      #1 reset_l = 1'b1;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      @(posedge clk);
      #1;
      start(1'b0, 4'd7, 8'd3);
      drain(23, 3, -1, 0, -1, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
